limb_master: RTL

- Initiator end of the LIMB byte-serial bus; the counterpart of the FPGA-side LIMB responder that masters the on-chip Wishbone bus.
- Converts single-word read/write requests from a local request port into LIMB frames.
- Drives limb_clk, limb_start, limb_nrd and limb_d, and honours limb_nwait.
- Used as the EC-side model in system benches and as the initiator in an FPGA-to-FPGA LIMB link.

---
 rtl/limb_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/limb_master.sv
// limb_master: initiator end of the LIMB byte-serial bus.
// Turns single-word read/write requests into LIMB frames
// (CMD, ADDR0..4, then WDATA0..3 or TURN + RDATA0..3, then DONE).
// Each frame byte occupies one bus period of 2*CLK_DIV clk cycles.
// The responder can stretch any period by holding limb_nwait low.
module limb_master #(
  parameter int CLK_DIV      = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [35:0] req_adr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdat,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdat,
  input  logic [7:0]  limb_d_in,
  output logic [7:0]  limb_d_out,
  output logic        limb_d_oe,
  output logic        limb_clk,
  output logic        limb_start,
  output logic        limb_nrd,
  input  logic        limb_nwait,
  input  logic        limb_nreq,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TURN, RDATA, DONE} state_t;

  localparam logic [8:0]  PHASE_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]  PHASE_HIGH = 9'(CLK_DIV);
  localparam logic [15:0] WAIT_LAST  = 16'(WAIT_TIMEOUT - 1);

  state_t      state, state_next;
  logic [8:0]  phase;
  logic [2:0]  byte_cnt;
  logic [15:0] wait_cnt;
  logic        ready_en;
  logic        lat_we;
  logic [35:0] lat_adr;
  logic [3:0]  lat_sel;
  logic [31:0] lat_wdat;
  logic [31:0] rdat_q;
  logic        err_q;
  logic        irq_meta, irq_q;

  logic        period_end, in_frame, advance, waited, timeout, accept;
  logic [39:0] addr_word;

  assign period_end = (phase == PHASE_LAST);
  assign in_frame   = (state inside {CMD, ADDR, WDATA, TURN, RDATA});
  assign advance    = in_frame && period_end && limb_nwait;
  assign waited     = in_frame && period_end && !limb_nwait;
  assign timeout    = waited && (wait_cnt == WAIT_LAST);
  assign accept     = req_valid && req_ready;
  assign addr_word  = {4'h0, lat_adr};

  assign rsp_err  = err_q;
  assign rsp_rdat = rdat_q;
  assign irq      = irq_q;

  // State register; reset drops any frame in flight straight back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: states advance only on accepted period ends; a timeout overrides everything.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = CMD;
      CMD:   if (advance) state_next = ADDR;
      ADDR:  if (advance && byte_cnt == 3'd4) state_next = lat_we ? WDATA : TURN;
      WDATA: if (advance && byte_cnt == 3'd3) state_next = DONE;
      TURN:  if (advance) state_next = RDATA;
      RDATA: if (advance && byte_cnt == 3'd3) state_next = DONE;
      DONE:  if (period_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = DONE;
  end

  // Bus outputs decoded from the current state, byte index and period phase.
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    limb_d_out = 8'h00;
    limb_d_oe  = 1'b0;
    limb_clk   = 1'b0;
    limb_start = 1'b0;
    limb_nrd   = 1'b1;
    case (state)
      IDLE: req_ready = ready_en;
      CMD: begin
        limb_start = 1'b1;
        limb_d_oe  = 1'b1;
        limb_d_out = {lat_we, 3'b000, lat_sel};
      end
      ADDR: begin
        limb_d_oe = 1'b1;
        case (byte_cnt)
          3'd0:    limb_d_out = addr_word[39:32];
          3'd1:    limb_d_out = addr_word[31:24];
          3'd2:    limb_d_out = addr_word[23:16];
          3'd3:    limb_d_out = addr_word[15:8];
          3'd4:    limb_d_out = addr_word[7:0];
          default: limb_d_out = 8'h00;
        endcase
      end
      WDATA: begin
        limb_d_oe = 1'b1;
        case (byte_cnt[1:0])
          2'd0:    limb_d_out = lat_wdat[31:24];
          2'd1:    limb_d_out = lat_wdat[23:16];
          2'd2:    limb_d_out = lat_wdat[15:8];
          default: limb_d_out = lat_wdat[7:0];
        endcase
      end
      TURN, RDATA: limb_nrd = 1'b0;
      DONE: rsp_valid = (phase == 9'd0);
      default: ;
    endcase
    if (in_frame) limb_clk = (phase >= PHASE_HIGH);
  end

  // Period timing, byte/wait counters, request latch and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
      phase    <= 9'd0;
      byte_cnt <= 3'd0;
      wait_cnt <= 16'd0;
      lat_we   <= 1'b0;
      lat_adr  <= 36'd0;
      lat_sel  <= 4'd0;
      lat_wdat <= 32'd0;
      rdat_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;

      if (state == IDLE || period_end) phase <= 9'd0;
      else                             phase <= phase + 9'd1;

      if (state_next != state) byte_cnt <= 3'd0;
      else if (advance)        byte_cnt <= byte_cnt + 3'd1;

      if (!in_frame || advance) wait_cnt <= 16'd0;
      else if (waited)          wait_cnt <= wait_cnt + 16'd1;

      if (accept) begin
        lat_we   <= req_we;
        lat_adr  <= req_adr;
        lat_sel  <= req_sel;
        lat_wdat <= req_wdat;
        rdat_q   <= 32'd0;
        err_q    <= 1'b0;
      end

      if (state == RDATA && advance) rdat_q <= {rdat_q[23:0], limb_d_in};

      if (timeout) begin
        err_q  <= 1'b1;
        rdat_q <= 32'd0;
      end
    end
  end

  // Two-flop synchroniser turning the active-low service request into irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_meta <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_meta <= ~limb_nreq;
      irq_q    <= irq_meta;
    end
  end

endmodule
